// File: rtl/mnist_dense_if.sv
// mnist_dense_if: RAM read port, start request and score/class results of the dense engine
interface mnist_dense_if #(
    parameter int ADDR_W = 12
) ();
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic              score_valid;
    logic [3:0]        score_idx;
    logic [31:0]       score;
    logic              done;
    logic [3:0]        class_idx;
    logic [31:0]       class_score;

    modport master (
        output start, mem_rdata,
        input  mem_addr, mem_we, busy, score_valid, score_idx, score, done, class_idx, class_score
    );

    modport slave (
        input  start, mem_rdata,
        output mem_addr, mem_we, busy, score_valid, score_idx, score, done, class_idx, class_score
    );
endinterface

// File: rtl/mnist_dense_engine.sv
// mnist_dense_engine: streams packed image and weights from RAM, computes 10 dot-product scores and their arg-max
module mnist_dense_engine #(
    parameter int ADDR_W   = 12,
    parameter int IMG_BASE = 0,
    parameter int W_BASE   = 256,
    parameter int N_WORDS  = 196,
    parameter int N_OUT    = 10
) (
    input logic         clk,
    input logic         rst_n,
    mnist_dense_if.slave bus
);
    localparam int KW = $clog2(N_WORDS);

    typedef enum logic [2:0] {IDLE, IMG, WGT, MAC, CMP, DONE} state_t;

    state_t             state;
    logic [KW-1:0]      k;
    logic [3:0]         n;
    logic [ADDR_W-1:0]  waddr;
    logic [31:0]        pix_reg;
    logic signed [31:0] acc;
    logic signed [31:0] max_score;
    logic [3:0]         max_idx;
    logic signed [18:0] lane_sum;
    logic signed [31:0] acc_nxt;
    logic               better;

    assign bus.mem_we = 1'b0;
    assign acc_nxt    = acc + {{13{lane_sum[18]}}, lane_sum};
    assign better     = acc > max_score;

    // Four-lane product sum: unsigned pixel lane times signed weight lane from the RAM word
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 4; i++)
            lane_sum = lane_sum + 19'($signed({1'b0, pix_reg[8*i +: 8]}) * $signed(bus.mem_rdata[8*i +: 8]));
    end

    // Sequencer: the weight address runs contiguously across neurons, so one incrementing pointer covers all of them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            k               <= '0;
            n               <= '0;
            waddr           <= ADDR_W'(W_BASE);
            pix_reg         <= '0;
            acc             <= '0;
            max_score       <= '0;
            max_idx         <= '0;
            bus.mem_addr    <= ADDR_W'(IMG_BASE);
            bus.busy        <= 1'b0;
            bus.score_valid <= 1'b0;
            bus.score_idx   <= '0;
            bus.score       <= '0;
            bus.done        <= 1'b0;
            bus.class_idx   <= '0;
            bus.class_score <= '0;
        end else begin
            bus.score_valid <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                IDLE: begin
                    bus.mem_addr <= ADDR_W'(IMG_BASE);
                    if (bus.start) begin
                        state     <= IMG;
                        n         <= '0;
                        k         <= '0;
                        acc       <= '0;
                        max_score <= 32'sh8000_0000;
                        max_idx   <= '0;
                        waddr     <= ADDR_W'(W_BASE);
                        bus.busy  <= 1'b1;
                    end
                end
                IMG: begin
                    state        <= WGT;
                    bus.mem_addr <= waddr;
                end
                WGT: begin
                    state   <= MAC;
                    pix_reg <= bus.mem_rdata;
                end
                MAC: begin
                    acc   <= acc_nxt;
                    waddr <= waddr + ADDR_W'(1);
                    if (k == KW'(N_WORDS - 1)) begin
                        state           <= CMP;
                        bus.score_valid <= 1'b1;
                        bus.score_idx   <= n;
                        bus.score       <= acc_nxt;
                    end else begin
                        state        <= IMG;
                        k            <= k + KW'(1);
                        bus.mem_addr <= ADDR_W'(IMG_BASE + int'(k) + 1);
                    end
                end
                CMP: begin
                    max_score    <= better ? acc : max_score;
                    max_idx      <= better ? n : max_idx;
                    k            <= '0;
                    acc          <= '0;
                    bus.mem_addr <= ADDR_W'(IMG_BASE);
                    if (n == 4'(N_OUT - 1)) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.class_idx   <= better ? n : max_idx;
                        bus.class_score <= better ? acc : max_score;
                    end else begin
                        state <= IMG;
                        n     <= n + 4'd1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.mem_addr <= ADDR_W'(IMG_BASE);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_dense_engine.sv
// tb_mnist_dense_engine: directed and random inferences against an arithmetic reference of the dense layer
module tb_mnist_dense_engine;
    localparam int IMG_BASE = 0;
    localparam int W_BASE   = 256;
    localparam int NW       = 196;
    localparam int NO       = 10;
    localparam int PER      = 3 * NW + 1;
    localparam int DONE_C   = NO * PER + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:4095];
    int exp_score [NO];
    int exp_cls, exp_cs;
    logic [3:0] held_ci;
    logic [31:0] held_cs;

    mnist_dense_if #(.ADDR_W(12)) bus ();

    mnist_dense_engine #(
        .ADDR_W(12), .IMG_BASE(IMG_BASE), .W_BASE(W_BASE), .N_WORDS(NW), .N_OUT(NO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model();
        int best;
        for (int n = 0; n < NO; n++) begin
            int s = 0;
            for (int j = 0; j < NW * 4; j++) begin
                logic [31:0] pw, ww;
                logic [7:0] pb, wb;
                pw = mem[IMG_BASE + j / 4];
                ww = mem[W_BASE + n * NW + j / 4];
                pb = pw[8 * (j % 4) +: 8];
                wb = ww[8 * (j % 4) +: 8];
                s += int'(pb) * int'($signed(wb));
            end
            exp_score[n] = s;
        end
        best = 32'h8000_0000;
        exp_cls = 0;
        for (int n = 0; n < NO; n++)
            if (exp_score[n] > best) begin
                best = exp_score[n];
                exp_cls = n;
            end
        exp_cs = best;
    endtask

    task automatic fill(input logic [31:0] img, input logic [31:0] w);
        for (int a = 0; a < NW; a++) mem[IMG_BASE + a] = img;
        for (int a = 0; a < NW * NO; a++) mem[W_BASE + a] = w;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {60'd0, bus.busy, bus.score_valid, bus.done, bus.mem_we}, 64'd0);
        chk({tag, "_addr"}, 64'(bus.mem_addr), 64'(IMG_BASE));
        chk({tag, "_score"}, {28'd0, bus.score_idx, bus.score}, 64'd0);
        chk({tag, "_class"}, {28'd0, bus.class_idx, bus.class_score}, 64'd0);
    endtask

    task automatic run(input int abort_at, input bit extra);
        model();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int c = 1; c <= DONE_C + 1; c++) begin
            bit sv;
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                held_ci = '0;
                held_cs = '0;
                for (int r = 0; r < 4; r++) begin
                    @(negedge clk);
                    chk("abort_quiet", {62'd0, bus.busy, bus.done}, 64'd0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            sv = (c % PER == 0) && (c < DONE_C);
            chk("ctrl", {60'd0, bus.busy, bus.score_valid, bus.done, bus.mem_we},
                {60'd0, c <= DONE_C, sv, c == DONE_C, 1'b0});
            if (sv) chk($sformatf("score%0d", c / PER - 1), {28'd0, bus.score_idx, bus.score},
                        {28'd0, 4'(c / PER - 1), 32'(exp_score[c / PER - 1])});
            if (c == DONE_C) begin
                held_ci = 4'(exp_cls);
                held_cs = 32'(exp_cs);
            end
            if (sv || c == 2 || c >= DONE_C - 1)
                chk("class", {28'd0, bus.class_idx, bus.class_score}, {28'd0, held_ci, held_cs});
            if (c == DONE_C + 1) chk("idle_addr", 64'(bus.mem_addr), 64'(IMG_BASE));
            bus.start = extra && (c == 100 || c == DONE_C);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        held_ci = '0;
        held_cs = '0;
        fill(32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        fill(32'h0, 32'h0);
        for (int a = 0; a < NW * NO; a++) mem[W_BASE + a] = $urandom;
        run(0, 1'b0);

        fill(32'hFFFF_FFFF, 32'h0);
        for (int n = 0; n < NO; n++)
            for (int a = 0; a < NW; a++) mem[W_BASE + n * NW + a] = {4{8'(n)}};
        run(0, 1'b1);

        fill(32'h0101_0101, 32'hFFFF_FFFF);
        for (int a = 0; a < NW; a++) mem[W_BASE + 3 * NW + a] = 32'h0101_0101;
        run(2000, 1'b0);
        run(0, 1'b0);

        fill(32'h0, 32'h0);
        mem[IMG_BASE] = 32'h0403_0201;
        mem[W_BASE + 5 * NW] = 32'h80FF_0201;
        run(0, 1'b0);

        for (int a = 0; a < NW; a++) mem[IMG_BASE + a] = $urandom;
        for (int a = 0; a < NW * NO; a++) mem[W_BASE + a] = $urandom;
        run(0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mnist_dense_engine.md
# mnist_dense_engine

Fully-connected output-layer engine for the MNIST classifier. It sits directly downstream of the data RAM and consumes its read port. It streams the 196-word packed image and the 1960-word packed weight set out of the RAM and computes the 10 neuron scores as signed dot products. It then reports the arg-max class.

## Interface
- `ADDR_W`, 12, RAM word-address width; must match the RAM.
- `IMG_BASE`, 0, word address of image word 0.
- `W_BASE`, 256, word address of weight word 0 for neuron 0.
- `N_WORDS`, 196, packed words per image and per neuron (784 bytes / 4).
- `N_OUT`, 10, number of neurons/classes.
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, reset. One clock; reset is asynchronous and active-low.
- `start`, in, 1, request one inference; sampled only in IDLE.
- `mem_addr`, out, ADDR_W, RAM address.
- `mem_we`, out, 1, RAM write enable; constant 0.
- `mem_rdata`, in, 32, RAM `data_out`; registered, 1-cycle read latency.
- `busy`, out, 1, high from the cycle after start is accepted until the DONE cycle (inclusive).
- `score_valid`, out, 1, one-cycle pulse per finished neuron.
- `score_idx`, out, 4, neuron index for `score_valid`.
- `score`, out, 32, signed neuron score for `score_valid`.
- `done`, out, 1, one-cycle pulse when the result is final.
- `class_idx`, out, 4, arg-max neuron, held until the next done.
- `class_score`, out, 32, signed score of `class_idx`, held.

## Operation
- Data packing: byte lane i = bits [8i+7:8i], i=0..3.
  - Image bytes are unsigned 8-bit pixels.
  - Weight bytes are signed 8-bit two's-complement.
  - Pixel lane i multiplies weight lane i.
- Addresses:
  - Image word k is at IMG_BASE+k.
  - Neuron n, weight word k is at W_BASE+n*N_WORDS+k. With defaults, the last weight word is at 2215.
- States: IDLE, IMG, WGT, MAC, CMP, DONE.
- IDLE:
  - `mem_addr`=IMG_BASE.
  - On start=1: n=0, k=0, acc=0, max_score=0x80000000, max_idx=0, then go to IMG.
- IMG: `mem_addr`=IMG_BASE+k; go to WGT.
- WGT: `mem_addr`=W_BASE+n*N_WORDS+k; latch `mem_rdata` (image word) into pix_reg; go to MAC.
- MAC:
  - acc += sum over i of (zero-extend pixel_i × sign-extend weight_i), using `mem_rdata` as the weight word.
  - Products are 17-bit signed. The 4-lane sum is sign-extended to 32 bits before adding.
  - acc is 32-bit two's-complement and wraps with no saturation (defaults cannot overflow: |acc| ≤ 255·128·784).
  - If k=N_WORDS-1, go to CMP; else k++ and go to IMG.
- CMP:
  - Pulse `score_valid` with `score_idx`=n and `score`=acc.
  - If acc > max_score (signed, strictly greater), update max_score and max_idx=n. Ties keep the lower index.
  - k=0, acc=0.
  - If n=N_OUT-1, go to DONE; else n++ and go to IMG.
- DONE: `class_idx`/`class_score` ← the max_idx/max_score values resulting from the final CMP; pulse `done`; go to IDLE.
- start is ignored in every state except IDLE, including DONE.

## Timing
- Reset values: all outputs 0 except `mem_addr`=IMG_BASE. State=IDLE; acc, counters and held results cleared.
- Reset mid-operation returns to IDLE immediately. No `done` is issued and the held class is cleared to 0.
- Each word costs 3 cycles (IMG, WGT, MAC). Each neuron costs 3·N_WORDS+1 cycles.
- With start accepted at edge 0:
  - IMG occupies cycle 1.
  - `score_valid` for neuron n is in cycle (n+1)(3·N_WORDS+1). With defaults: 589, 1178, …, 5890.
  - `done` is in cycle N_OUT(3·N_WORDS+1)+1 = 5891.
  - `busy`=1 in cycles 1..5891.
- A new start is accepted no earlier than the cycle after `done`.
- `class_idx`/`class_score` change only in the DONE cycle.

## Test plan
- All image words 0, arbitrary weights → all 10 scores 0; `class_idx`=0, `class_score`=0; `done` at cycle 5891.
- Pixels all 0xFF; every weight byte of neuron n = n → score n = n·199920; `class_idx`=9, `class_score`=1799280.
- Pixels all 0x01; neuron 3 weights 0x01, all others 0xFF (−1) → scores −784 except neuron 3 = +784; `class_idx`=3.
- Lane check: image word 0 = 0x04030201, other image words 0; neuron 5 word 0 = 0x80FF0201, all other weights 0 → score 5 = 1+4−3−512 = −510, others 0; `class_idx`=0 (tie at 0 keeps the lowest index).
- Start pulsed again at cycle 100 and in the DONE cycle → ignored; exactly one `done`; `busy` is continuous 1..5891. `mem_we` stays 0 throughout.
- `rst_n` asserted at cycle 2000 → all outputs 0 asynchronously, no `done`. A restart after release completes normally with correct results.
